// File: rtl/figure2_40_42_mux.sv
// figure2_40_42_mux: two equivalent 2:1 mux forms, a registered copy, a disagreement flag and a select-toggle counter
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   x1, x2     data inputs (x1 when s=0, x2 when s=1)
//   s          select, shared by all bits
//   f2_40      AND/OR/NOT mux output
//   f2_42      conditional-select mux output
//   f_q        f2_42 registered
//   mismatch   sticky flag, set when the two mux forms disagree on an edge
//   s_toggles  saturating count of edge-sampled changes of s
module figure2_40_42_mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             s,
  output logic [WIDTH-1:0] f2_40,
  output logic [WIDTH-1:0] f2_42,
  output logic [WIDTH-1:0] f_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] s_toggles
);
  logic [WIDTH-1:0] w_s_vec;
  logic             w_toggle;
  logic [WIDTH-1:0] r_f_q;
  logic             r_mismatch;
  logic             r_s_prev;
  logic [CNT_W-1:0] r_cnt;
  assign w_s_vec  = {WIDTH{s}};
  assign f2_40    = (~w_s_vec & x1) | (w_s_vec & x2);
  assign f2_42    = s ? x2 : x1;
  // only changes visible at the sampling edge count, and the counter sticks at all-ones
  assign w_toggle = (s != r_s_prev) && !(&r_cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_f_q      <= '0;
      r_mismatch <= 1'b0;
      r_s_prev   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_f_q      <= f2_42;
      r_mismatch <= r_mismatch | (|(f2_40 ^ f2_42));
      r_s_prev   <= s;
      r_cnt      <= w_toggle ? r_cnt + CNT_W'(1) : r_cnt;
    end
  assign f_q       = r_f_q;
  assign mismatch  = r_mismatch;
  assign s_toggles = r_cnt;
endmodule

// File: tb/tb_figure2_40_42_mux.sv
// tb_figure2_40_42_mux: directed checks of both mux forms, registered path, toggle counter and async reset
module tb_figure2_40_42_mux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s = 1'b0;
  logic       xa1 = 1'b0, xa2 = 1'b0;
  logic [3:0] xb1 = 4'h0, xb2 = 4'h0;
  logic       fa_40, fa_42, fa_q, mm_a;
  logic [7:0] tog_a;
  logic [3:0] fb_40, fb_42, fb_q;
  logic       mm_b;
  logic [1:0] tog_b;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] tt_exp = 8'b1101_1000;
  logic [2:0] idx;
  always #5 clk = ~clk;
  figure2_40_42_mux u_a (
    .clk(clk), .rst_n(rst_n), .x1(xa1), .x2(xa2), .s(s),
    .f2_40(fa_40), .f2_42(fa_42), .f_q(fa_q), .mismatch(mm_a), .s_toggles(tog_a)
  );
  figure2_40_42_mux #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .x1(xb1), .x2(xb2), .s(s),
    .f2_40(fb_40), .f2_42(fb_42), .f_q(fb_q), .mismatch(mm_b), .s_toggles(tog_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    #1;
    chk("rst f_q", 32'(fa_q), 0);
    chk("rst mismatch", 32'(mm_a), 0);
    chk("rst toggles", 32'(tog_a), 0);
    chk("rst f_q w4", 32'(fb_q), 0);
    chk("rst toggles w4", 32'(tog_b), 0);
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {xa1, xa2, s} = idx;
      #40;
      chk($sformatf("tt f2_40 %03b", idx), 32'(fa_40), 32'(tt_exp[idx]));
      chk($sformatf("tt f2_42 %03b", idx), 32'(fa_42), 32'(tt_exp[idx]));
    end
    chk("tt f_q held in reset", 32'(fa_q), 0);
    @(negedge clk);
    xa1 = 1'b1; xa2 = 1'b0; s = 1'b0; xb1 = 4'hA; xb2 = 4'h5;
    rst_n = 1'b1;
    #1;
    chk("f_q before edge", 32'(fa_q), 0);
    chk("w4 f2_40 s0", 32'(fb_40), 32'hA);
    chk("w4 f2_42 s0", 32'(fb_42), 32'hA);
    @(negedge clk);
    chk("f_q after edge", 32'(fa_q), 1);
    chk("toggles no change", 32'(tog_a), 0);
    chk("w4 f_q s0", 32'(fb_q), 32'hA);
    s = 1'b1;
    #1;
    chk("w4 f2_40 s1", 32'(fb_40), 32'h5);
    chk("w4 f2_42 s1", 32'(fb_42), 32'h5);
    @(negedge clk);
    chk("w4 f_q s1", 32'(fb_q), 32'h5);
    chk("f_q s1", 32'(fa_q), 0);
    s = 1'b0; @(negedge clk);
    s = 1'b1; @(negedge clk);
    // a glitch on s between edges must not be counted
    #1 s = 1'b1; #1 s = 1'b0; #1 s = 1'b1;
    s = 1'b0; @(negedge clk);
    chk("toggles after 4", 32'(tog_a), 4);
    chk("mismatch after 4", 32'(mm_a), 0);
    chk("w4 toggles sat 4", 32'(tog_b), 3);
    s = 1'b1; @(negedge clk);
    s = 1'b0; @(negedge clk);
    chk("toggles after 6", 32'(tog_a), 6);
    chk("w4 toggles sat 6", 32'(tog_b), 3);
    chk("w4 mismatch", 32'(mm_b), 0);
    chk("f_q pre-reset", 32'(fa_q), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async f_q", 32'(fa_q), 0);
    chk("async toggles", 32'(tog_a), 0);
    chk("async toggles w4", 32'(tog_b), 0);
    chk("async f_q w4", 32'(fb_q), 0);
    chk("async f2_40", 32'(fa_40), 1);
    chk("async f2_42", 32'(fa_42), 1);
    s = 1'b1;
    #1;
    chk("async f2_40 s1", 32'(fa_40), 0);
    chk("async f2_42 s1", 32'(fa_42), 0);
    chk("async w4 f2_42 s1", 32'(fb_42), 32'h5);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release toggles", 32'(tog_a), 1);
    chk("release toggles w4", 32'(tog_b), 1);
    chk("release f_q", 32'(fa_q), 0);
    chk("release mismatch", 32'(mm_a), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/figure2_40_42_mux.md
FIGURE2_40_42_MUX -- requirements
Module: figure2_40_42_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width of x1, x2 and all data outputs.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the select-toggle counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port x1, input, WIDTH bits: data input selected when s=0.
REQ-006 Port x2, input, WIDTH bits: data input selected when s=1.
REQ-007 Port s, input, 1 bit: select, common to all bits.
REQ-008 Port f2_40, output, WIDTH bits: combinational mux output, sum-of-products form.
REQ-009 Port f2_42, output, WIDTH bits: combinational mux output, conditional-select form.
REQ-010 Port f_q, output, WIDTH bits: registered copy of f2_42.
REQ-011 Port mismatch, output, 1 bit: sticky flag, set when the two combinational forms disagree.
REQ-012 Port s_toggles, output, CNT_W bits: saturating count of clock-sampled changes of s.

Function
REQ-013 f2_40 SHALL equal, per bit, (NOT s AND x1) OR (s AND x2), built from AND/OR/NOT logic; it has no dependence on clk or rst_n.
REQ-014 f2_42 SHALL equal x1 when s=0 and x2 when s=1, built as a conditional select; it has no dependence on clk or rst_n.
REQ-015 For all 0/1 inputs f2_40 and f2_42 SHALL be identical; both update within the same delta as their inputs, with zero-cycle latency.
REQ-016 f_q SHALL load f2_42 on every rising clk edge while rst_n=1, giving one-cycle latency.
REQ-017 mismatch SHALL set to 1 on a rising edge where f2_40 != f2_42, compared bitwise OR-reduced.
REQ-018 Once set, mismatch SHALL hold 1 until rst_n is asserted.
REQ-019 The block SHALL hold an internal register s_prev, loaded with s on every rising edge.
REQ-020 On each rising edge where s != s_prev, s_toggles SHALL increment by 1.
REQ-021 s_toggles SHALL saturate at 2^CNT_W-1 and never wrap to zero.
REQ-022 Changes of s between clock edges that return to the prior value before the next edge SHALL NOT be counted.
REQ-023 The combinational outputs SHALL remain valid and correct while rst_n=0.

Reset
REQ-024 While rst_n=0, asynchronously and regardless of clk: f_q=0, mismatch=0, s_toggles=0, s_prev=0.
REQ-025 Reset asserted mid-operation SHALL clear the registers immediately, not at the next edge.
REQ-026 On release of rst_n, the first rising edge SHALL resume normal updates; that edge SHALL compare s against s_prev=0.

Verification
REQ-027 Truth table: step {x1,x2} through 00,00,01,01,10,10,11,11 every 40 ns while s toggles every 40 ns starting at 0, covering all 8 combinations -> f2_40=f2_42 at every step: (x1,x2,s)=(0,1,0)->0, (0,1,1)->1, (1,0,0)->1, (1,0,1)->0, (1,1,x)->1, (0,0,x)->0.
REQ-028 Registered path: rst_n=1, x1=1, x2=0, s=0, apply one rising edge -> f_q=1 after that edge, and f_q does not change before it.
REQ-029 Toggle count: after reset, drive s=1,0,1,0 on four consecutive edges -> s_toggles=4 and mismatch=0.
REQ-030 Saturation: CNT_W=2, toggle s on 6 consecutive edges -> s_toggles sticks at 3.
REQ-031 Async reset: with f_q=1 and s_toggles=3, drop rst_n between edges -> f_q=0 and s_toggles=0 immediately, while f2_40 and f2_42 still track the inputs.
REQ-032 Width: WIDTH=4, x1=4'hA, x2=4'h5, s=0 then 1 -> f2_40=f2_42=4'hA, then 4'h5.
